seq_detect_param: RTL and testbench

SEQ_DETECT_PARAM -- requirements
Module: seq_detect_param

---
 rtl/seq_detect_param.sv | 141 ++++++++++++++
 tb/tb_seq_detect_param.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_detect_param.sv
// seq_detect_param
//   Serial pattern detector with a runtime-loadable pattern of 2..MAX_LEN bits,
//   selectable overlapping / non-overlapping detection and a saturating match
//   counter.
//
//   Ports
//     clk, rst         clock; asynchronous active-high reset
//     cfg_load         load cfg_pattern / cfg_len / cfg_overlap
//     cfg_pattern      target pattern, bit cfg_len-1 oldest, bit 0 newest
//     cfg_len          active pattern length
//     cfg_overlap      1 = overlapping detection, 0 = non-overlapping
//     din_valid, din   serial data input
//     clr_cnt          clear match counter
//     match            one-cycle pulse per detected pattern
//     match_cnt        saturating match count
//     armed            high while a legal configuration is held
//     cfg_err          set when the last cfg_load was illegal
//
//   state  | meaning
//   -------+-------------------------------------------
//   S_IDLE | no legal configuration, input ignored
//   S_RUN  | configuration latched, detecting
module seq_detect_param #(
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 16,
    localparam int LW     = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LW-1:0]      cfg_len,
    input  logic               cfg_overlap,
    input  logic               din_valid,
    input  logic               din,
    input  logic               clr_cnt,
    output logic               match,
    output logic [CNT_W-1:0]   match_cnt,
    output logic               armed,
    output logic               cfg_err
);

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t             state_q, state_d;
    logic [MAX_LEN-1:0] hist_q,  hist_d;
    logic [LW-1:0]      fill_q,  fill_d;
    logic [MAX_LEN-1:0] pat_q,   pat_d;
    logic [LW-1:0]      len_q,   len_d;
    logic               ovl_q,   ovl_d;
    logic               err_q,   err_d;
    logic               match_q, match_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;

    logic [MAX_LEN-1:0] hist_shift;
    logic [LW-1:0]      fill_inc;
    logic [MAX_LEN-1:0] len_mask;
    logic               cfg_ok;
    logic               hit;

    always_comb begin
        state_d = state_q;
        hist_d  = hist_q;
        fill_d  = fill_q;
        pat_d   = pat_q;
        len_d   = len_q;
        ovl_d   = ovl_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        hit     = 1'b0;

        cfg_ok     = (cfg_len >= LW'(2)) && (cfg_len <= LW'(MAX_LEN));
        hist_shift = {hist_q[MAX_LEN-2:0], din};
        fill_inc   = (fill_q < len_q) ? fill_q + LW'(1) : len_q;
        // Only the low len_q history bits take part in the compare.
        len_mask   = ~({MAX_LEN{1'b1}} << len_q);

        if (cfg_load) begin
            // A load wins over any data bit in the same cycle.
            hist_d = '0;
            fill_d = '0;
            if (cfg_ok) begin
                pat_d   = cfg_pattern;
                len_d   = cfg_len;
                ovl_d   = cfg_overlap;
                err_d   = 1'b0;
                state_d = S_RUN;
            end else begin
                err_d   = 1'b1;
                state_d = S_IDLE;
            end
        end else if (state_q == S_RUN && din_valid) begin
            hit = (fill_inc == len_q) && (((hist_shift ^ pat_q) & len_mask) == '0);
            if (hit && !ovl_q) begin
                hist_d = '0;
                fill_d = '0;
            end else begin
                hist_d = hist_shift;
                fill_d = fill_inc;
            end
        end

        if (clr_cnt) begin
            cnt_d = hit ? CNT_W'(1) : '0;
        end else if (hit && cnt_q != {CNT_W{1'b1}}) begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        match_d = hit;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            hist_q  <= '0;
            fill_q  <= '0;
            pat_q   <= '0;
            len_q   <= '0;
            ovl_q   <= 1'b0;
            err_q   <= 1'b0;
            match_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            hist_q  <= hist_d;
            fill_q  <= fill_d;
            pat_q   <= pat_d;
            len_q   <= len_d;
            ovl_q   <= ovl_d;
            err_q   <= err_d;
            match_q <= match_d;
            cnt_q   <= cnt_d;
        end
    end

    assign match     = match_q;
    assign match_cnt = cnt_q;
    assign armed     = (state_q == S_RUN);
    assign cfg_err   = err_q;

endmodule

// File: tb/tb_seq_detect_param.sv
module tb_seq_detect_param;

    localparam int MAX_LEN = 8;
    localparam int CNT_W   = 2;
    localparam int LW      = $clog2(MAX_LEN + 1);
    localparam int CMAX    = (1 << CNT_W) - 1;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               cfg_load = 1'b0;
    logic [MAX_LEN-1:0] cfg_pattern = '0;
    logic [LW-1:0]      cfg_len = '0;
    logic               cfg_overlap = 1'b0;
    logic               din_valid = 1'b0;
    logic               din = 1'b0;
    logic               clr_cnt = 1'b0;
    logic               match;
    logic [CNT_W-1:0]   match_cnt;
    logic               armed;
    logic               cfg_err;

    int checks = 0;
    int failures = 0;

    seq_detect_param #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
        .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .din_valid(din_valid),
        .din(din), .clr_cnt(clr_cnt), .match(match), .match_cnt(match_cnt),
        .armed(armed), .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    // Reference model: configuration plus a queue of the most recent bits
    // since the last restart point (oldest at index 0).
    bit                 m_run;
    logic [MAX_LEN-1:0] m_pat;
    int                 m_len;
    bit                 m_ovl;
    bit                 m_err;
    bit                 m_match;
    int                 m_cnt;
    bit                 m_q[$];

    function automatic void model_reset();
        m_run = 0; m_pat = '0; m_len = 0; m_ovl = 0; m_err = 0;
        m_match = 0; m_cnt = 0; m_q.delete();
    endfunction

    function automatic void model_step(bit ld, logic [MAX_LEN-1:0] pat, int len, bit ovl,
                                       bit v, bit d, bit clr);
        bit hit = 0;
        if (ld) begin
            m_q.delete();
            if (len >= 2 && len <= MAX_LEN) begin
                m_run = 1; m_pat = pat; m_len = len; m_ovl = ovl; m_err = 0;
            end else begin
                m_run = 0; m_err = 1;
            end
        end else if (m_run && v) begin
            m_q.push_back(d);
            if (m_q.size() > m_len) void'(m_q.pop_front());
            if (m_q.size() == m_len) begin
                hit = 1;
                for (int i = 0; i < m_len; i++)
                    if (m_q[i] != m_pat[m_len-1-i]) hit = 0;
            end
            if (hit && !m_ovl) m_q.delete();
        end
        if (clr) m_cnt = hit ? 1 : 0;
        else if (hit && m_cnt < CMAX) m_cnt++;
        m_match = hit;
    endfunction

    // One clock: drive inputs, take the edge, update the model, settle.
    task automatic cyc(bit ld, logic [MAX_LEN-1:0] pat, int len, bit ovl,
                       bit v, bit d, bit clr);
        cfg_load = ld; cfg_pattern = pat; cfg_len = LW'(len); cfg_overlap = ovl;
        din_valid = v; din = d; clr_cnt = clr;
        @(posedge clk);
        model_step(ld, pat, len, ovl, v, d, clr);
        #1;
        cfg_load = 0; din_valid = 0; clr_cnt = 0;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        #2;
        model_reset();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if ({match, match_cnt, armed, cfg_err} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got match=%b cnt=%0d armed=%b err=%b want all 0",
                     match, match_cnt, armed, cfg_err);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_overlap();
        bit exp_m[5] = '{0, 0, 1, 0, 1};
        bit bits[5]  = '{1, 0, 1, 0, 1};
        cyc(1, 8'b101, 3, 1, 0, 0, 1);
        checks++;
        if (armed !== 1'b1) begin
            failures++; $display("FAIL overlap_armed: got %b want 1", armed);
        end
        for (int i = 0; i < 5; i++) begin
            cyc(0, '0, 0, 0, 1, bits[i], 0);
            checks++;
            if (match !== exp_m[i]) begin
                failures++; $display("FAIL overlap_match bit%0d: got %b want %b", i+1, match, exp_m[i]);
            end
        end
        cyc(0, '0, 0, 0, 0, 0, 0);
        checks++;
        if (match !== 1'b0 || match_cnt !== 2'd2) begin
            failures++; $display("FAIL overlap_cnt: got match=%b cnt=%0d want 0/2", match, match_cnt);
        end
    endtask

    task automatic test_nonoverlap();
        bit exp_m[5] = '{0, 0, 1, 0, 0};
        bit bits[5]  = '{1, 0, 1, 0, 1};
        cyc(1, 8'b101, 3, 0, 0, 0, 1);
        for (int i = 0; i < 5; i++) begin
            cyc(0, '0, 0, 0, 1, bits[i], 0);
            checks++;
            if (match !== exp_m[i]) begin
                failures++; $display("FAIL nonoverlap_match bit%0d: got %b want %b", i+1, match, exp_m[i]);
            end
        end
        checks++;
        if (match_cnt !== 2'd1) begin
            failures++; $display("FAIL nonoverlap_cnt: got %0d want 1", match_cnt);
        end
    endtask

    task automatic test_gapped();
        bit bits[4] = '{1, 1, 0, 1};
        int pulses = 0;
        cyc(1, 8'b1101, 4, 1, 0, 0, 1);
        for (int i = 0; i < 4; i++) begin
            cyc(0, '0, 0, 0, 1, bits[i], 0);
            checks++;
            if (match !== (i == 3)) begin
                failures++; $display("FAIL gapped_match bit%0d: got %b want %b", i+1, match, i == 3);
            end
            pulses += match;
            for (int g = 0; g < 2; g++) begin
                cyc(0, '0, 0, 0, 0, $urandom_range(0, 1), 0);
                checks++;
                if (match !== 1'b0) begin
                    failures++; $display("FAIL gapped_gap bit%0d: got %b want 0", i+1, match);
                end
                pulses += match;
            end
        end
        checks++;
        if (pulses != 1) begin
            failures++; $display("FAIL gapped_pulses: got %0d want 1", pulses);
        end
    endtask

    task automatic test_illegal();
        int lens[2] = '{0, MAX_LEN + 1};
        for (int k = 0; k < 2; k++) begin
            cyc(1, 8'b11, lens[k], 1, 0, 0, 1);
            checks++;
            if (cfg_err !== 1'b1 || armed !== 1'b0) begin
                failures++; $display("FAIL illegal_len%0d: got err=%b armed=%b want 1/0", lens[k], cfg_err, armed);
            end
            for (int i = 0; i < 6; i++) begin
                cyc(0, '0, 0, 0, 1, 1, 0);
                checks++;
                if (match !== 1'b0) begin
                    failures++; $display("FAIL illegal_nomatch len%0d: got %b want 0", lens[k], match);
                end
            end
        end
        cyc(1, 8'b11, 2, 1, 0, 0, 0);
        checks++;
        if (cfg_err !== 1'b0 || armed !== 1'b1) begin
            failures++; $display("FAIL illegal_recover: got err=%b armed=%b want 0/1", cfg_err, armed);
        end
    endtask

    task automatic test_saturation();
        cyc(1, 8'b11, 2, 1, 0, 0, 1);
        for (int i = 0; i < 6; i++) begin
            cyc(0, '0, 0, 0, 1, 1, 0);
            checks++;
            if (match !== (i >= 1) || match_cnt !== CNT_W'(i < 4 ? i : 3)) begin
                failures++;
                $display("FAIL sat_bit%0d: got match=%b cnt=%0d want %b/%0d", i+1, match, match_cnt,
                         i >= 1, i < 4 ? i : 3);
            end
        end
        cyc(0, '0, 0, 0, 1, 1, 1);
        checks++;
        if (match !== 1'b1 || match_cnt !== 2'd1) begin
            failures++; $display("FAIL sat_clr_on_match: got match=%b cnt=%0d want 1/1", match, match_cnt);
        end
        cyc(0, '0, 0, 0, 0, 0, 1);
        checks++;
        if (match_cnt !== 2'd0) begin
            failures++; $display("FAIL sat_clr: got %0d want 0", match_cnt);
        end
    endtask

    task automatic test_cfg_priority();
        cyc(1, 8'b11, 2, 1, 0, 0, 0);
        cyc(0, '0, 0, 0, 1, 1, 0);
        cyc(0, '0, 0, 0, 1, 1, 0);
        checks++;
        if (match !== 1'b1 || match_cnt !== 2'd1) begin
            failures++; $display("FAIL prio_setup: got match=%b cnt=%0d want 1/1", match, match_cnt);
        end
        // Reload alongside a valid bit that would otherwise match.
        cyc(1, 8'b11, 2, 1, 1, 1, 0);
        checks++;
        if (match !== 1'b0 || match_cnt !== 2'd1) begin
            failures++; $display("FAIL prio_load: got match=%b cnt=%0d want 0/1", match, match_cnt);
        end
        cyc(0, '0, 0, 0, 1, 1, 0);
        checks++;
        if (match !== 1'b0) begin
            failures++; $display("FAIL prio_refill: got %b want 0", match);
        end
        cyc(0, '0, 0, 0, 1, 1, 0);
        checks++;
        if (match !== 1'b1 || match_cnt !== 2'd2) begin
            failures++; $display("FAIL prio_after: got match=%b cnt=%0d want 1/2", match, match_cnt);
        end
    endtask

    task automatic test_reset_mid();
        cyc(1, 8'b101, 3, 1, 0, 0, 0);
        cyc(0, '0, 0, 0, 1, 1, 0);
        cyc(0, '0, 0, 0, 1, 0, 0);
        rst = 1'b1;
        #1;
        checks++;
        if (armed !== 1'b0 || match_cnt !== 2'd0) begin
            failures++; $display("FAIL rstmid_during: got armed=%b cnt=%0d want 0/0", armed, match_cnt);
        end
        rst = 1'b0;
        model_reset();
        cyc(0, '0, 0, 0, 1, 1, 0);
        checks++;
        if (match !== 1'b0 || armed !== 1'b0) begin
            failures++; $display("FAIL rstmid_unarmed: got match=%b armed=%b want 0/0", match, armed);
        end
        cyc(1, 8'b101, 3, 1, 0, 0, 0);
        cyc(0, '0, 0, 0, 1, 1, 0);
        checks++;
        if (match !== 1'b0 || match_cnt !== 2'd0 || armed !== 1'b1) begin
            failures++;
            $display("FAIL rstmid_reload: got match=%b cnt=%0d armed=%b want 0/0/1", match, match_cnt, armed);
        end
    endtask

    task automatic test_random();
        logic [MAX_LEN-1:0] pat;
        int len, ptr;
        bit ovl, ld, v, d, clr;
        pat = MAX_LEN'($urandom);
        len = MAX_LEN;
        ovl = 1;
        ptr = 0;
        cyc(1, pat, len, ovl, 0, 0, 1);
        for (int n = 0; n < 600; n++) begin
            ld  = ($urandom_range(0, 39) == 0);
            clr = ($urandom_range(0, 24) == 0);
            v   = ($urandom_range(0, 9) < 8);
            if (ld) begin
                pat = MAX_LEN'($urandom);
                len = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 1) * (MAX_LEN + 1)
                                                  : $urandom_range(2, MAX_LEN);
                ovl = $urandom_range(0, 1);
                ptr = 0;
            end
            if (len >= 2 && len <= MAX_LEN && $urandom_range(0, 3) != 0) begin
                d = pat[len-1-ptr];
                if (v) ptr = (ptr + 1) % len;
            end else begin
                d = $urandom_range(0, 1);
            end
            cyc(ld, pat, len, ovl, v, d, clr);
            checks++;
            if (match !== m_match || match_cnt !== CNT_W'(m_cnt) || armed !== m_run || cfg_err !== m_err) begin
                failures++;
                $display("FAIL random_cycle%0d: got match=%b cnt=%0d armed=%b err=%b want %b/%0d/%b/%b",
                         n, match, match_cnt, armed, cfg_err, m_match, m_cnt, m_run, m_err);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_overlap();
        test_nonoverlap();
        test_gapped();
        test_illegal();
        test_saturation();
        test_cfg_priority();
        test_reset_mid();
        pulse_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
